song_seq: RTL
=============

SONG_SEQ -- requirements
Module: song_seq

Interface
REQ-001 Parameter NUM_SONGS, default 4: number of songs held; power of two, 2..8.
REQ-002 Parameter SONG_DEPTH, default 32: entries per song; power of two, 16..128.
REQ-003 Parameter NUM_VOICES, default 3: voice slots for chord notes, 1..4.
REQ-004 Parameter NOTE_W, default 6, and DUR_W, default 6: note and duration field widths; entry width EW = 1+NOTE_W+DUR_W+3.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 play  in  1  one-cycle start pulse; honoured only in IDLE.
REQ-008 song_sel  in  clog2(NUM_SONGS)  song to play; sampled on an accepted play.
REQ-009 pause  in  1  level; while high, beat counting freezes.
REQ-010 beat  in  1  one-cycle beat strobe from the beat generator.
REQ-011 note_valid  out  1  note offer to the note players.
REQ-012 note_ready  in  1  downstream accepts; a transfer occurs when note_valid and note_ready are both high.
REQ-013 note_voice  out  clog2(NUM_VOICES)  target voice slot.
REQ-014 note  out  NOTE_W  note number; 0 = rest.
REQ-015 note_dur  out  DUR_W  duration in beats.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 song_done  out  1  one-cycle pulse when the song ends.

Function
REQ-018 Entry layout, MSB to LSB: adv, note, dur, meta[2:0]; meta is ignored.
REQ-019 ROM addressing: {song, index}; the ROM is read synchronously with a 1-cycle latency.
REQ-020 States: IDLE, FETCH, DECODE, ISSUE, WAIT, DONE.
REQ-021 IDLE + play: latch song_sel, set index=0, set voice=0, go to FETCH; play is ignored in all other states.
REQ-022 FETCH: drive the ROM address, go to DECODE; no outputs change.
REQ-023 DECODE, end marker (adv=1 and dur=0): go to DONE.
REQ-024 DECODE, note=0 and adv=1: skip ISSUE and go to WAIT with count=dur.
REQ-025 DECODE, note=0 and adv=0: advance index and go to FETCH.
REQ-026 DECODE, note≠0: load the output registers and go to ISSUE.
REQ-027 ISSUE: hold note_valid=1; note, note_dur and note_voice stay stable until the transfer.
REQ-028 ISSUE transfer, adv=0 (chord member): voice increments, saturating at NUM_VOICES-1 so excess chord notes reuse the last slot; advance index; go to FETCH.
REQ-029 ISSUE transfer, adv=1: go to WAIT with count=dur.
REQ-030 WAIT: decrement count on each beat while pause=0; beats seen while pause=1 are lost, not queued.
REQ-031 WAIT exit, count reaching 0: reset voice to 0, advance index, go to FETCH.
REQ-032 Index wrap: advancing from SONG_DEPTH-1 goes to DONE instead of FETCH; the index never wraps into the next song.
REQ-033 DONE: assert song_done for exactly one cycle, then go to IDLE.
REQ-034 Latency: play to first note_valid is exactly 3 cycles for a non-rest entry 0 (play edge, FETCH, DECODE; valid in the 4th).
REQ-035 Simultaneous beat and transfer in ISSUE: the beat is not counted; counting starts in WAIT.
REQ-036 Pause in FETCH, DECODE or ISSUE has no effect.
REQ-037 Song contents are fixed per song; unused entries hold the end marker.

Reset
REQ-038 On reset_n=0 at a clock edge: state=IDLE, note_valid=0, note=0, note_dur=0, note_voice=0, busy=0, song_done=0, index=0, count=0.
REQ-039 Reset mid-operation aborts immediately; no song_done pulse and no partial transfer completes.

Structure
REQ-040 A shared package song_pkg holds the entry field widths, the field-offset constants, the end-marker encoding and the state enumeration.
REQ-041 The ROM is a sub-module song_bank_rom (parameters NUM_SONGS, SONG_DEPTH; registered dout); song_seq holds the FSM, counters and output registers.

Verification
REQ-042 Song 0 = {adv0 n52 d12, adv0 n56 d8, adv1 n59 d4, end}, note_ready=1, beat every 10 cycles -> three transfers with voice 0,1,2; song_done asserted after the 4th following beat.
REQ-043 Same song with note_ready low for 5 cycles on the 1st offer -> valid held, fields stable, transfer on ready, sequence otherwise unchanged.
REQ-044 Entry {adv1 n0 d3} -> no note_valid; exactly 3 beats consumed before the next fetch.
REQ-045 pause=1 over 2 beats during a d=4 WAIT -> 6 beats total elapse before the next fetch.
REQ-046 Song with no end marker and all SONG_DEPTH entries used -> song_done after entry SONG_DEPTH-1; address never reaches the next song.
REQ-047 reset_n low in WAIT, then play with song_sel=1 -> outputs at reset values, then the first entry of song 1 is offered 3 cycles after play.

Source files
------------

// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: entry layout, end marker, FSM states.
package song_pkg;

    localparam int unsigned DEF_NOTE_W = 6;
    localparam int unsigned DEF_DUR_W  = 6;
    localparam int unsigned META_W     = 3;

    // Entry layout, MSB to LSB: adv, note, dur, meta.
    localparam int unsigned DUR_LSB = META_W;

    function automatic int unsigned note_lsb(input int unsigned dur_w);
        return META_W + dur_w;
    endfunction

    function automatic int unsigned adv_bit(input int unsigned note_w, input int unsigned dur_w);
        return META_W + dur_w + note_w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned note_w, input int unsigned dur_w);
        return 1 + note_w + dur_w + META_W;
    endfunction

    // End marker: advance flag set with a zero duration.
    localparam logic        END_ADV = 1'b1;
    localparam int unsigned END_DUR = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/song_bank_rom.sv
// Fixed song contents, addressed as {song, index}, with a registered read port.
module song_bank_rom
    import song_pkg::*;
#(
    parameter  int unsigned NUM_SONGS  = 4,
    parameter  int unsigned SONG_DEPTH = 32,
    parameter  int unsigned NOTE_W     = DEF_NOTE_W,
    parameter  int unsigned DUR_W      = DEF_DUR_W,
    localparam int unsigned IW         = $clog2(SONG_DEPTH),
    localparam int unsigned AW         = $clog2(NUM_SONGS) + IW,
    localparam int unsigned EW         = entry_w(NOTE_W, DUR_W)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [EW-1:0] dout
);

    function automatic logic [EW-1:0] ent(input int adv, input int nt, input int dur, input int meta);
        return {1'(adv), NOTE_W'(nt), DUR_W'(dur), META_W'(meta)};
    endfunction

    // Song table; every slot not listed holds the end marker.
    function automatic logic [EW-1:0] entry_at(input int s, input int i);
        logic [EW-1:0] e;
        e = ent(int'(END_ADV), 0, int'(END_DUR), 0);
        case (s)
            0: begin
                case (i)
                    0:       e = ent(0, 52, 12, 0);
                    1:       e = ent(0, 56, 8, 0);
                    2:       e = ent(1, 59, 4, 0);
                    default: ;
                endcase
            end
            1: begin
                case (i)
                    0:       e = ent(1, 60, 4, 0);
                    1:       e = ent(1, 0, 3, 0);
                    2:       e = ent(0, 0, 5, 0);
                    3:       e = ent(0, 62, 2, 1);
                    4:       e = ent(0, 63, 2, 2);
                    5:       e = ent(0, 1, 2, 3);
                    6:       e = ent(1, 2, 2, 4);
                    default: ;
                endcase
            end
            2:       e = ent(1, (i % 63) + 1, (i % 3) + 1, i % 8);
            default: ;
        endcase
        return e;
    endfunction

    // Synchronous read, one cycle of latency.
    always_ff @(posedge clk) begin
        if (en) begin
            dout <= entry_at(int'(addr[AW-1:IW]), int'(addr[IW-1:0]));
        end
    end

endmodule

// File: rtl/song_seq.sv
// Song sequencer: walks a song in ROM, offers notes to voice slots, waits on beats.
module song_seq
    import song_pkg::*;
#(
    parameter  int unsigned NUM_SONGS  = 4,
    parameter  int unsigned SONG_DEPTH = 32,
    parameter  int unsigned NUM_VOICES = 3,
    parameter  int unsigned NOTE_W     = DEF_NOTE_W,
    parameter  int unsigned DUR_W      = DEF_DUR_W,
    localparam int unsigned SW         = $clog2(NUM_SONGS),
    localparam int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic [SW-1:0]     song_sel,
    input  logic              pause,
    input  logic              beat,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [VW-1:0]     note_voice,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  note_dur,
    output logic              busy,
    output logic              song_done
);

    localparam int unsigned IW         = $clog2(SONG_DEPTH);
    localparam int unsigned AW         = SW + IW;
    localparam int unsigned EW         = entry_w(NOTE_W, DUR_W);
    localparam int unsigned ADV_BIT    = adv_bit(NOTE_W, DUR_W);
    localparam int unsigned NOTE_LSB   = note_lsb(DUR_W);
    localparam int unsigned LAST_IDX   = SONG_DEPTH - 1;
    localparam int unsigned LAST_VOICE = NUM_VOICES - 1;

    state_e              state_q, state_d;
    logic [SW-1:0]       song_q, song_d;
    logic [IW-1:0]       index_q, index_d;
    logic [VW-1:0]       voice_q, voice_d;
    logic [DUR_W-1:0]    count_q, count_d;
    logic                adv_q, adv_d;

    logic                note_valid_q, note_valid_d;
    logic [VW-1:0]       note_voice_q, note_voice_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    note_dur_q, note_dur_d;
    logic                busy_q, busy_d;
    logic                song_done_q, song_done_d;

    logic [EW-1:0]       rom_dout;
    logic                rom_adv;
    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;
    logic                is_end;
    logic                beat_ok;
    logic                xfer;
    logic                do_advance;
    logic                unused_meta;

    song_bank_rom #(
        .NUM_SONGS  (NUM_SONGS),
        .SONG_DEPTH (SONG_DEPTH),
        .NOTE_W     (NOTE_W),
        .DUR_W      (DUR_W)
    ) u_rom (
        .clk  (clk),
        .en   (state_q == ST_FETCH),
        .addr (AW'({song_q, index_q})),
        .dout (rom_dout)
    );

    assign rom_adv     = rom_dout[ADV_BIT];
    assign rom_note    = rom_dout[NOTE_LSB +: NOTE_W];
    assign rom_dur     = rom_dout[DUR_LSB +: DUR_W];
    assign unused_meta = ^rom_dout[META_W-1:0];
    assign is_end      = (rom_adv == END_ADV) && (rom_dur == DUR_W'(END_DUR));
    assign beat_ok     = beat & ~pause;
    assign xfer        = note_valid_q & note_ready;

    // State, sequencing registers and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            song_q       <= '0;
            index_q      <= '0;
            voice_q      <= '0;
            count_q      <= '0;
            adv_q        <= 1'b0;
            note_valid_q <= 1'b0;
            note_voice_q <= '0;
            note_q       <= '0;
            note_dur_q   <= '0;
            busy_q       <= 1'b0;
            song_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            index_q      <= index_d;
            voice_q      <= voice_d;
            count_q      <= count_d;
            adv_q        <= adv_d;
            note_valid_q <= note_valid_d;
            note_voice_q <= note_voice_d;
            note_q       <= note_d;
            note_dur_q   <= note_dur_d;
            busy_q       <= busy_d;
            song_done_q  <= song_done_d;
        end
    end

    // Next-state logic: song walk, voice allocation and beat counting.
    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        index_d    = index_q;
        voice_d    = voice_q;
        count_d    = count_q;
        adv_d      = adv_q;
        do_advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    song_d  = song_sel;
                    index_d = '0;
                    voice_d = '0;
                    count_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_end) begin
                    state_d = ST_DONE;
                end else if (rom_note == '0) begin
                    if (rom_adv) begin
                        count_d = rom_dur;
                        state_d = ST_WAIT;
                    end else begin
                        do_advance = 1'b1;
                    end
                end else begin
                    adv_d   = rom_adv;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    if (adv_q) begin
                        count_d = note_dur_q;
                        state_d = ST_WAIT;
                    end else begin
                        // Excess chord notes pile onto the last voice slot.
                        if (voice_q != VW'(LAST_VOICE)) begin
                            voice_d = voice_q + 1'b1;
                        end
                        do_advance = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (beat_ok) begin
                    count_d = count_q - 1'b1;
                    if (count_q == DUR_W'(1)) begin
                        voice_d    = '0;
                        do_advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stepping past the last slot ends the song rather than spilling into the next one.
        if (do_advance) begin
            if (index_q == IW'(LAST_IDX)) begin
                state_d = ST_DONE;
            end else begin
                index_d = index_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    // Output register next values, derived from the upcoming state.
    always_comb begin
        note_valid_d = (state_d == ST_ISSUE);
        note_voice_d = note_voice_q;
        note_d       = note_q;
        note_dur_d   = note_dur_q;
        busy_d       = (state_d != ST_IDLE);
        song_done_d  = (state_d == ST_DONE);

        if ((state_q == ST_DECODE) && (state_d == ST_ISSUE)) begin
            note_d       = rom_note;
            note_dur_d   = rom_dur;
            note_voice_d = voice_q;
        end
    end

    assign note_valid = note_valid_q;
    assign note_voice = note_voice_q;
    assign note       = note_q;
    assign note_dur   = note_dur_q;
    assign busy       = busy_q;
    assign song_done  = song_done_q;

endmodule
